// File: rtl/fft_wb_bank_router_pkg.sv
// fft_pkg: shared definitions for the FFT write-back bank router.
//   BW_DEF / N_LOG2_DEF : default sample width and log2 FFT size
//   wb_state_e          : write-back FSM states (IDLE, RUN, DONE)
//   parity32            : XOR parity of a sample address (selects the bank)
//   bitrev32            : bit-reverse the low n bits of an address
package fft_pkg;

  localparam int BW_DEF     = 32;
  localparam int N_LOG2_DEF = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } wb_state_e;

  function automatic logic parity32(input logic [31:0] x);
    return ^x;
  endfunction

  // Bits at and above n come back as zero.
  function automatic logic [31:0] bitrev32(input logic [31:0] x, input int unsigned n);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if (i < int'(n)) begin
        r[5'(int'(n) - 1 - i)] = x[5'(i)];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_wb_bank_router_if.sv
// fft_wb_bank_router_if: butterfly-pair input stream of the write-back router.
//   in_valid / in_ready : handshake, pair taken when both are high
//   in_data1            : upper butterfly output (sample address a)
//   in_data2            : lower butterfly output (sample address b)
// master = butterfly datapath side, slave = bank router side.
interface fft_wb_bank_router_if
  import fft_pkg::*;
#(
  parameter int BW = BW_DEF
);
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_data1;
  logic [BW-1:0] in_data2;

  modport master (output in_valid, output in_data1, output in_data2, input in_ready);
  modport slave  (input in_valid, input in_data1, input in_data2, output in_ready);
endinterface

// File: rtl/fft_wb_bank_router_addr_gen.sv
// fft_wb_addr_gen: combinational in-place address generator.
//   k      : butterfly index within the stage, 0 .. N/2-1
//   stage  : stage index s (must be < N_LOG2)
//   addr_a : bank word address of sample a (a >> 1)
//   addr_b : bank word address of sample b (b >> 1)
//   swap   : parity(a); 1 means sample a lives in bank 1
// With FFT_WB_BITREV_LAST_EN defined, the last stage bit-reverses a and b
// before the word address is taken; bank choice is unaffected because
// bit reversal keeps parity.
module fft_wb_addr_gen
  import fft_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEF,
  parameter int SW     = $clog2(N_LOG2)
) (
  input  logic [N_LOG2-2:0] k,
  input  logic [SW-1:0]     stage,
  output logic [N_LOG2-2:0] addr_a,
  output logic [N_LOG2-2:0] addr_b,
  output logic              swap
);

  localparam logic [SW-1:0]     LAST_STAGE = SW'(N_LOG2 - 1);
  localparam logic [N_LOG2-1:0] ONE        = N_LOG2'(1);

  logic [SW-1:0]     sh_s;
  logic [N_LOG2-1:0] span_s;
  logic [N_LOG2-1:0] k_ext_s;
  logic [N_LOG2-1:0] j_s;
  logic [N_LOG2-1:0] g_s;
  logic [N_LOG2-1:0] a_s;
  logic [N_LOG2-1:0] b_s;
  logic [N_LOG2-1:0] a_fin_s;
  logic [N_LOG2-1:0] b_fin_s;
  logic [31:0]       a_rev_s;
  logic [31:0]       b_rev_s;

  // span = N >> (s+1) = 1 << (N_LOG2-1-s); a = 2*g*span + j; b sets bit log2(span).
  always_comb begin
    sh_s    = LAST_STAGE - stage;
    span_s  = ONE << sh_s;
    k_ext_s = {1'b0, k};
    j_s     = k_ext_s & (span_s - ONE);
    g_s     = k_ext_s >> sh_s;
    a_s     = ((g_s << 1) << sh_s) | j_s;
    b_s     = a_s | span_s;
    swap    = parity32(32'(a_s));
    a_rev_s = bitrev32(32'(a_s), N_LOG2);
    b_rev_s = bitrev32(32'(b_s), N_LOG2);
`ifdef FFT_WB_BITREV_LAST_EN
    if (stage == LAST_STAGE) begin
      a_fin_s = N_LOG2'(a_rev_s);
      b_fin_s = N_LOG2'(b_rev_s);
    end else begin
      a_fin_s = a_s;
      b_fin_s = b_s;
    end
`else
    if (stage == LAST_STAGE) begin
      a_fin_s = a_s ^ N_LOG2'(a_rev_s & 32'd0);
      b_fin_s = b_s ^ N_LOG2'(b_rev_s & 32'd0);
    end else begin
      a_fin_s = a_s;
      b_fin_s = b_s;
    end
`endif
    addr_a = (N_LOG2-1)'(a_fin_s >> 1);
    addr_b = (N_LOG2-1)'(b_fin_s >> 1);
  end

endmodule

// File: rtl/fft_wb_bank_router.sv
// fft_wb_bank_router: write-back side of the two-bank in-place FFT memory.
// Takes butterfly output pairs in butterfly order, computes both in-place
// sample addresses for the current stage and steers each sample to its
// parity bank (bank = parity(addr), word = addr >> 1).
// Ports:
//   clk, rstn           : clock, synchronous active-low reset
//   start, stage        : one-cycle stage kick-off, stage index sampled on start
//   in_if (slave)       : in_valid/in_ready/in_data1/in_data2 pair stream
//   bank0_*, bank1_*    : single-port bank write ports (registered)
//   stage_done          : one-cycle pulse with the last pair's write
//   stage_err           : sticky, start seen with stage >= N_LOG2
// Optional macro FFT_WB_BITREV_LAST_EN: natural-order addresses on the last stage.
module fft_wb_bank_router
  import fft_pkg::*;
#(
  parameter int BW     = BW_DEF,
  parameter int N_LOG2 = N_LOG2_DEF,
  parameter int SW     = $clog2(N_LOG2)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [SW-1:0]        stage,
  fft_wb_bank_router_if.slave  in_if,
  output logic                 bank0_we,
  output logic [N_LOG2-2:0]    bank0_addr,
  output logic [BW-1:0]        bank0_wdata,
  output logic                 bank1_we,
  output logic [N_LOG2-2:0]    bank1_addr,
  output logic [BW-1:0]        bank1_wdata,
  output logic                 stage_done,
  output logic                 stage_err
);

  localparam logic [N_LOG2-2:0] K_LAST = {(N_LOG2-1){1'b1}};
  localparam logic [N_LOG2-2:0] K_ONE  = (N_LOG2-1)'(1);

  wb_state_e         state_q, state_d;
  logic [N_LOG2-2:0] k_q, k_d;
  logic [SW-1:0]     stage_q, stage_d;
  logic              in_ready_q, in_ready_d;
  logic              b0_we_q, b0_we_d;
  logic [N_LOG2-2:0] b0_addr_q, b0_addr_d;
  logic [BW-1:0]     b0_wdata_q, b0_wdata_d;
  logic              b1_we_q, b1_we_d;
  logic [N_LOG2-2:0] b1_addr_q, b1_addr_d;
  logic [BW-1:0]     b1_wdata_q, b1_wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              accept_s;
  logic              stage_ok_s;
  logic [N_LOG2-2:0] addr_a_s;
  logic [N_LOG2-2:0] addr_b_s;
  logic              swap_s;

  fft_wb_addr_gen #(
    .N_LOG2 (N_LOG2),
    .SW     (SW)
  ) u_addr_gen (
    .k      (k_q),
    .stage  (stage_q),
    .addr_a (addr_a_s),
    .addr_b (addr_b_s),
    .swap   (swap_s)
  );

  // in_ready_q is only ever high in RUN, so it doubles as the RUN qualifier.
  assign accept_s   = in_if.in_valid && in_ready_q;
  assign stage_ok_s = (32'(stage) < 32'(N_LOG2));

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    stage_d    = stage_q;
    err_d      = err_q;
    b0_we_d    = 1'b0;
    b0_addr_d  = b0_addr_q;
    b0_wdata_d = b0_wdata_q;
    b1_we_d    = 1'b0;
    b1_addr_d  = b1_addr_q;
    b1_wdata_d = b1_wdata_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (stage_ok_s) begin
            state_d = RUN;
            stage_d = stage;
            k_d     = '0;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (accept_s) begin
          k_d = k_q + K_ONE;
          if (k_q == K_LAST) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Un-swap: the sample whose address has odd parity goes to bank 1.
    if (accept_s) begin
      b0_we_d = 1'b1;
      b1_we_d = 1'b1;
      if (swap_s) begin
        b0_addr_d  = addr_b_s;
        b0_wdata_d = in_if.in_data2;
        b1_addr_d  = addr_a_s;
        b1_wdata_d = in_if.in_data1;
      end else begin
        b0_addr_d  = addr_a_s;
        b0_wdata_d = in_if.in_data1;
        b1_addr_d  = addr_b_s;
        b1_wdata_d = in_if.in_data2;
      end
    end else begin
      b0_we_d = 1'b0;
      b1_we_d = 1'b0;
    end

    in_ready_d = (state_d == RUN);
    done_d     = (state_d == DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      k_q        <= '0;
      stage_q    <= '0;
      in_ready_q <= 1'b0;
      b0_we_q    <= 1'b0;
      b0_addr_q  <= '0;
      b0_wdata_q <= '0;
      b1_we_q    <= 1'b0;
      b1_addr_q  <= '0;
      b1_wdata_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      stage_q    <= stage_d;
      in_ready_q <= in_ready_d;
      b0_we_q    <= b0_we_d;
      b0_addr_q  <= b0_addr_d;
      b0_wdata_q <= b0_wdata_d;
      b1_we_q    <= b1_we_d;
      b1_addr_q  <= b1_addr_d;
      b1_wdata_q <= b1_wdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign bank0_we       = b0_we_q;
  assign bank0_addr     = b0_addr_q;
  assign bank0_wdata    = b0_wdata_q;
  assign bank1_we       = b1_we_q;
  assign bank1_addr     = b1_addr_q;
  assign bank1_wdata    = b1_wdata_q;
  assign stage_done     = done_q;
  assign stage_err      = err_q;

endmodule

// File: tb/tb_fft_wb_bank_router.sv
// Scoreboard bench for fft_wb_bank_router at N_LOG2=3 (N=8, 4 pairs/stage).
// The driver pushes the hand-computed bank writes of every accepted pair;
// the monitor pops and compares on each cycle with a write enable.
module tb_fft_wb_bank_router;

  localparam int BW     = 32;
  localparam int N_LOG2 = 3;
  localparam int SW     = 2;

  logic          clk   = 1'b0;
  logic          rstn  = 1'b0;
  logic          start = 1'b0;
  logic [SW-1:0] stage = 2'd0;

  logic          b0_we, b1_we, stage_done, stage_err;
  logic [1:0]    b0_addr, b1_addr;
  logic [31:0]   b0_wd, b1_wd;

  always #5 clk = ~clk;

  fft_wb_bank_router_if #(.BW(BW)) in_if ();

  fft_wb_bank_router #(
    .BW     (BW),
    .N_LOG2 (N_LOG2),
    .SW     (SW)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .stage       (stage),
    .in_if       (in_if),
    .bank0_we    (b0_we),
    .bank0_addr  (b0_addr),
    .bank0_wdata (b0_wd),
    .bank1_we    (b1_we),
    .bank1_addr  (b1_addr),
    .bank1_wdata (b1_wd),
    .stage_done  (stage_done),
    .stage_err   (stage_err)
  );

  typedef struct {
    logic [1:0]  a0;
    logic [31:0] d0;
    logic [1:0]  a1;
    logic [31:0] d1;
    logic        done;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks     = 0;
  int   errors     = 0;
  int   exp_dones  = 0;
  int   seen_dones = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Hand-computed {swap, a>>1, b>>1} per (stage, k) for N=8.
  function automatic logic [4:0] vec(input int s, input int k);
    logic [4:0] t [0:15];
    t = '{5'b00010, 5'b10010, 5'b10111, 5'b00111,   // s0: (0,4)(1,5)(2,6)(3,7)
          5'b00001, 5'b10001, 5'b11011, 5'b01011,   // s1: (0,2)(1,3)(4,6)(5,7)
`ifdef FFT_WB_BITREV_LAST_EN
          5'b00010, 5'b10111, 5'b10010, 5'b00111,   // s2 reversed: (0,4)(2,6)(1,5)(3,7)
`else
          5'b00000, 5'b10101, 5'b11010, 5'b01111,   // s2: (0,1)(2,3)(4,5)(6,7)
`endif
          5'b00000, 5'b00000, 5'b00000, 5'b00000};
    return t[s*4 + k];
  endfunction

  task automatic send(input int s, input int k);
    logic [4:0]  v;
    logic [31:0] d1, d2;
    exp_t        e;
    int          n;
    d1 = 32'hA000_0000 + 32'(s * 16 + k);
    d2 = 32'hB000_0000 + 32'(s * 16 + k);
    in_if.in_valid = 1'b1;
    in_if.in_data1 = d1;
    in_if.in_data2 = d2;
    n = 0;
    while (in_if.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (in_if.in_ready !== 1'b1) begin
      chk("accept_timeout", 64'(in_if.in_ready), 64'd1);
      in_if.in_valid = 1'b0;
      return;
    end
    v = vec(s, k);
    if (v[4]) begin
      e.a0 = v[1:0]; e.d0 = d2; e.a1 = v[3:2]; e.d1 = d1;
    end else begin
      e.a0 = v[3:2]; e.d0 = d1; e.a1 = v[1:0]; e.d1 = d2;
    end
    e.done = (k == 3);
    if (e.done) exp_dones++;
    sb_q.push_back(e);
    @(negedge clk);
    in_if.in_valid = 1'b0;
  endtask

  task automatic run_stage(input int s, input bit gap);
    for (int k = 0; k < 4; k++) begin
      send(s, k);
      if (gap) @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_start(input int s);
    start = 1'b1;
    stage = SW'(s);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"}, 64'(in_if.in_ready), 64'd0);
    chk({tag, "_we"}, 64'({b0_we, b1_we}), 64'd0);
    chk({tag, "_addr"}, 64'({b0_addr, b1_addr}), 64'd0);
    chk({tag, "_wdata"}, {b0_wd, b1_wd}, 64'd0);
    chk({tag, "_done"}, 64'(stage_done), 64'd0);
    chk({tag, "_err"}, 64'(stage_err), 64'd0);
  endtask

  // Monitor: every write cycle must match the oldest expected pair.
  always @(negedge clk) begin
    if (b0_we === 1'b1 || b1_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got b0 %0h@%0d b1 %0h@%0d expected none", b0_wd, b0_addr, b1_wd, b1_addr);
      end else begin
        mon_e = sb_q.pop_front();
        chk("we_pair", 64'({b0_we, b1_we}), 64'd3);
        chk("bank0_addr", 64'(b0_addr), 64'(mon_e.a0));
        chk("bank0_wdata", 64'(b0_wd), 64'(mon_e.d0));
        chk("bank1_addr", 64'(b1_addr), 64'(mon_e.a1));
        chk("bank1_wdata", 64'(b1_wd), 64'(mon_e.d1));
        chk("stage_done", 64'(stage_done), 64'(mon_e.done));
      end
    end else if (stage_done === 1'b1) begin
      chk("done_without_write", 64'(stage_done), 64'd0);
    end
    if (stage_done === 1'b1) seen_dones++;
  end

  initial begin
    in_if.in_valid = 1'b0;
    in_if.in_data1 = 32'd0;
    in_if.in_data2 = 32'd0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 64'(in_if.in_ready), 64'd0);

    // Valid pairs while idle must be ignored.
    in_if.in_valid = 1'b1;
    in_if.in_data1 = 32'hDEAD_0001;
    in_if.in_data2 = 32'hDEAD_0002;
    repeat (3) @(negedge clk);
    in_if.in_valid = 1'b0;
    chk("idle_valid_ready", 64'(in_if.in_ready), 64'd0);

    // Stage 0, back-to-back pairs.
    pulse_start(0);
    chk("ready_after_start", 64'(in_if.in_ready), 64'd1);
    run_stage(0, 1'b0);
    chk("ready_after_done", 64'(in_if.in_ready), 64'd0);

    // Out-of-range stage sets sticky error, no run.
    pulse_start(3);
    chk("err_set", 64'(stage_err), 64'd1);
    chk("err_ready", 64'(in_if.in_ready), 64'd0);
    repeat (3) @(negedge clk);
    chk("err_sticky", 64'(stage_err), 64'd1);
    chk("err_ready_hold", 64'(in_if.in_ready), 64'd0);

    // Start during RUN is ignored: stage 0 addressing and k continue.
    pulse_start(0);
    send(0, 0);
    send(0, 1);
    pulse_start(2);
    send(0, 2);
    send(0, 3);
    repeat (2) @(negedge clk);

    // Stage 2 with valid toggling every cycle.
    pulse_start(2);
    run_stage(2, 1'b1);

    // Reset after two accepted pairs of stage 1.
    pulse_start(1);
    send(1, 0);
    send(1, 1);
    rstn = 1'b0;
    @(negedge clk);
    chk_zero("midreset");
    rstn = 1'b1;
    @(negedge clk);
    pulse_start(1);
    run_stage(1, 1'b0);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    chk("done_count", 64'(seen_dones), 64'(exp_dones));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
